// File: rtl/axi_wr_arb_pkg.sv
// rtl/axi_wr_arb_pkg.sv - shared state type, burst constant and size helper for the write arbiter
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AW   = 2'd1,
    ARB_W    = 2'd2,
    ARB_B    = 2'd3
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AWSIZE encoding: log2 of the beat width in bytes
  function automatic logic [2:0] axi_size_code(input int beat_bytes);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == beat_bytes) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int  NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

  localparam logic [IDX_W:0] PORTS = (IDX_W + 1)'(NUM_PORTS);

  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // one extra bit lets ptr+k exceed NUM_PORTS-1 before the modulo fold
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= PORTS) cand = cand - PORTS;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// rtl/axi4_wr_arbiter.sv - round-robin AXI4 write arbiter holding one grant from AW through B
module axi4_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int  NUM_PORTS  = 4,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 512,
  parameter int  ID_WIDTH   = 4,
  localparam int BEAT_BYTES = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic [NUM_PORTS*8-1:0]           s_axi_awlen,
  input  logic [NUM_PORTS-1:0]             s_axi_awvalid,
  output logic [NUM_PORTS-1:0]             s_axi_awready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [NUM_PORTS*BEAT_BYTES-1:0]  s_axi_wstrb,
  input  logic [NUM_PORTS-1:0]             s_axi_wlast,
  input  logic [NUM_PORTS-1:0]             s_axi_wvalid,
  output logic [NUM_PORTS-1:0]             s_axi_wready,
  output logic [NUM_PORTS*2-1:0]           s_axi_bresp,
  output logic [NUM_PORTS-1:0]             s_axi_bvalid,
  input  logic [NUM_PORTS-1:0]             s_axi_bready,
  output logic [ID_WIDTH-1:0]              m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [BEAT_BYTES-1:0]            m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [ID_WIDTH-1:0]              m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             err_wlast,
  output logic                             err_bid
);

  localparam logic [2:0]       SIZE_CODE = axi_size_code(BEAT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PORTS - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [7:0]           beat_cnt;
  logic [7:0]           beat_cnt_max;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;

  logic [ADDR_WIDTH-1:0] aw_addr [NUM_PORTS];
  logic [7:0]            aw_len  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_data  [NUM_PORTS];
  logic [BEAT_BYTES-1:0] w_strb  [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign aw_addr[i] = s_axi_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_len[i]  = s_axi_awlen[i*8 +: 8];
    assign w_data[i]  = s_axi_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb[i]  = s_axi_wstrb[i*BEAT_BYTES +: BEAT_BYTES];
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req   (s_axi_awvalid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  logic in_aw, in_w, in_b, last_gen, aw_hs, w_hs, b_hs;

  assign in_aw    = (state == ARB_AW);
  assign in_w     = (state == ARB_W);
  assign in_b     = (state == ARB_B);
  assign last_gen = (beat_cnt == beat_cnt_max);

  assign m_axi_awid    = ID_WIDTH'(grant_idx);
  assign m_axi_awaddr  = aw_addr[grant_idx];
  assign m_axi_awlen   = aw_len[grant_idx];
  assign m_axi_awsize  = SIZE_CODE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = in_aw & s_axi_awvalid[grant_idx];

  // wlast is regenerated from the latched length so a misbehaving writer cannot cut a burst short
  assign m_axi_wdata  = w_data[grant_idx];
  assign m_axi_wstrb  = w_strb[grant_idx];
  assign m_axi_wlast  = in_w & last_gen;
  assign m_axi_wvalid = in_w & s_axi_wvalid[grant_idx];

  assign m_axi_bready = in_b & s_axi_bready[grant_idx];
  assign s_axi_bresp  = {NUM_PORTS{m_axi_bresp}};

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;

  always_comb begin
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    if (in_aw) s_axi_awready[grant_idx] = m_axi_awready;
    if (in_w)  s_axi_wready[grant_idx]  = m_axi_wready;
    if (in_b)  s_axi_bvalid[grant_idx]  = m_axi_bvalid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      beat_cnt     <= '0;
      beat_cnt_max <= '0;
      err_wlast    <= 1'b0;
      err_bid      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|arb_grant) begin
            grant_idx <= arb_idx;
            state     <= ARB_AW;
          end
        end
        ARB_AW: begin
          if (aw_hs) begin
            beat_cnt_max <= aw_len[grant_idx];
            beat_cnt     <= '0;
            state        <= ARB_W;
          end
        end
        ARB_W: begin
          if (w_hs) begin
            if (s_axi_wlast[grant_idx] != last_gen) err_wlast <= 1'b1;
            if (last_gen) state <= ARB_B;
            else          beat_cnt <= beat_cnt + 8'd1;
          end
        end
        ARB_B: begin
          if (m_axi_bvalid && (m_axi_bid != ID_WIDTH'(grant_idx))) err_bid <= 1'b1;
          if (b_hs) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_wr_arbiter.md
# axi4_wr_arbiter

Round-robin arbiter that shares one AXI4 write master port between NUM_PORTS packet-writer instances (AXI-stream-to-AXI4 burst writers, one per ingress stream). It grants one requester at a time and carries that requester's AW, W and B channels. The grant is held from address acceptance until the write response, so each burst is atomic and only one transaction is outstanding. It sits between the writers and the memory interconnect, fixes AWSIZE/AWBURST, and reports protocol violations through sticky error flags.

## Interface
- NUM_PORTS, 4: number of requesters (2..16)
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 512: data width; BEAT_BYTES = DATA_WIDTH/8
- ID_WIDTH, 4: AXI ID width; must be ≥ clog2(NUM_PORTS)
- Clock and reset (already decided): one clock `clk`; reset `rst_n` is synchronous and active-low.
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- s_axi_awaddr / s_axi_awlen  in  NUM_PORTS×ADDR_WIDTH / NUM_PORTS×8  per-port burst address and length, flattened, port 0 in the LSBs
- s_axi_awvalid / s_axi_awready  in / out  NUM_PORTS each  per-port AW handshake
- s_axi_wdata / s_axi_wstrb  in  NUM_PORTS×DATA_WIDTH / NUM_PORTS×BEAT_BYTES  per-port write data and byte strobes
- s_axi_wlast, s_axi_wvalid / s_axi_wready  in / out  NUM_PORTS each  per-port W handshake
- s_axi_bresp  out  NUM_PORTS×2  per-port write response
- s_axi_bvalid / s_axi_bready  out / in  NUM_PORTS each  per-port B handshake
- m_axi_awid, m_axi_awaddr, m_axi_awlen  out  ID_WIDTH, ADDR_WIDTH, 8  granted burst; awid = zero-extended grant index
- m_axi_awsize / m_axi_awburst  out  3 / 2  constant clog2(BEAT_BYTES) / 2'b01 (INCR)
- m_axi_awvalid / m_axi_awready  out / in  1  master AW handshake
- m_axi_wdata, m_axi_wstrb, m_axi_wlast  out  DATA_WIDTH, BEAT_BYTES, 1  granted write beat
- m_axi_wvalid / m_axi_wready  out / in  1  master W handshake
- m_axi_bid, m_axi_bresp  in  ID_WIDTH, 2  write response
- m_axi_bvalid / m_axi_bready  in / out  1  master B handshake
- grant_idx  out  clog2(NUM_PORTS)  currently or last granted port; reset 0
- err_wlast / err_bid  out  1 each  sticky protocol-error flags; cleared only by reset

## Operation
- State machine with four states: ARB_IDLE → ARB_AW → ARB_W → ARB_B → ARB_IDLE.
- **ARB_IDLE:** if any s_axi_awvalid is set, pick a port by round-robin, register it into grant_idx, and go to ARB_AW.
  - Search order: rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
- **ARB_AW:**
  - Master AW fields come from the granted port.
  - m_axi_awvalid = s_axi_awvalid[grant]; s_axi_awready[grant] = m_axi_awready.
  - On handshake: latch awlen into beat_cnt_max, clear beat_cnt, go to ARB_W.
- **ARB_W:**
  - W fields are muxed from the granted port; wvalid and wready are coupled in both directions.
  - m_axi_wlast is generated by the arbiter as (beat_cnt == beat_cnt_max). It is not taken from the requester.
  - If s_axi_wlast[grant] ≠ the generated last on any accepted beat, set err_wlast.
  - On the accepted beat with generated last: go to ARB_B.
- **ARB_B:**
  - m_axi_bready = s_axi_bready[grant]; s_axi_bvalid[grant] = m_axi_bvalid; bresp is passed through.
  - If m_axi_bid ≠ grant_idx, set err_bid; the response is still routed to the granted port.
  - On handshake: rr_ptr = grant+1 (wrapping to 0 after NUM_PORTS-1), go to ARB_IDLE.
- Non-granted ports, and all ports in ARB_IDLE, see every ready and bvalid at 0.
- A requester may assert wvalid before its AW is granted; it is held off with wready = 0.
- awlen = 0 (single beat): the first accepted beat carries last.

## Timing
- Reset (rst_n low at a clock edge):
  - State goes to ARB_IDLE; rr_ptr, grant_idx and the beat counters go to 0; err flags are cleared.
  - m_axi_awvalid, m_axi_wvalid, m_axi_bready, and all s_axi_awready, s_axi_wready and s_axi_bvalid are 0.
  - Reset mid-burst abandons the burst with no drain.
- All channel outputs are combinational from state, grant_idx and the inputs; there is no data pipeline.
- Arbitration latency: awvalid seen in ARB_IDLE → m_axi_awvalid asserted in the next cycle.
- Turnarounds:
  - AW handshake → W beats may start in the next cycle.
  - Last-beat handshake → ARB_B in the next cycle.
  - B handshake → ARB_IDLE in the next cycle; the next grant follows one cycle after that.
- Minimum per-burst overhead is 3 idle/handshake cycles beyond the data beats.
- A requester whose awvalid rises while another burst is in flight waits; no preemption.
- beat_cnt is 8 bits, compared against the latched awlen, and does not wrap within a legal burst.

## Structure
- Package axi_wr_arb_pkg holds:
  - the arb_state_t enum (ARB_IDLE, ARB_AW, ARB_W, ARB_B);
  - AXI_BURST_INCR = 2'b01;
  - size-code function clog2(BEAT_BYTES).
- Sub-module rr_arbiter (NUM_PORTS): combinational request vector + rr_ptr → one-hot grant and index.
- Top level contains the FSM, beat counter, channel muxes and error flags.

## Test plan
- **Single requester:** port 2 issues awaddr 0x1000, awlen 3, 4 beats, bresp OKAY → m_axi_awid = 2, m_axi_wlast on beat 4 only, s_axi_bvalid[2] pulses; all other ports idle.
- **Contention:** ports 0, 1 and 3 assert awvalid in the same cycle with rr_ptr = 0 → grants 0, 1, 3 in order, each burst atomic, no interleaved W beats.
- **Backpressure:** m_axi_awready delayed 5 cycles, m_axi_wready toggling, m_axi_bvalid delayed 10 cycles → no beat dropped or duplicated, grant held throughout, data matches the source.
- **Protocol errors:** requester asserts wlast on beat 2 of awlen 3 → err_wlast = 1 and the master still ends the burst on beat 4; bid = 5 while grant = 1 → err_bid = 1 and the response goes to port 1.
- **Reset mid-burst:** rst_n low for 1 cycle during ARB_W beat 2 → all valids and readys are 0 on the next edge, state is ARB_IDLE, rr_ptr = 0, err flags are 0.
- **Single-beat fairness:** awlen 0 on all four ports held continuously → grants rotate 0, 1, 2, 3, 0 with wlast on every beat.
